// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared constants and types for the instruction-fetch front end
package if_fetch_pkg;

    localparam logic RstEnable  = 1'b1;
    localparam logic RstDisable = 1'b0;
    localparam logic Stop       = 1'b1;
    localparam logic NoStop     = 1'b0;

    localparam int InstAddrBusW = 32;
    localparam int InstBusW     = 32;

    localparam logic [InstBusW-1:0]     ZeroWord         = 32'h0000_0000;
    localparam logic [InstAddrBusW-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One prefetched instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [InstAddrBusW-1:0] pc;
        logic [InstBusW-1:0]     inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// rtl/if_fetch_fifo.sv - synchronous FIFO with push/pop/flush used for prefetch data and pc tags
module fetch_fifo
    import if_fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q;
    logic [PW-1:0]    wr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_pop;
    logic             do_push;

    // Explicit wrap so a non-power-of-two depth still indexes correctly.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    // Pointers and occupancy; flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (rst == RstEnable || flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            assert (!(push_i && full_o && !do_pop));
            if (do_push) begin
                wr_q <= ptr_next(wr_q);
            end
            if (do_pop) begin
                rd_q <= ptr_next(rd_q);
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch: PC owner, ROM requester, prefetch buffer and IF/ID hand-off
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2,
    parameter int          MAX_OUT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  pause,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic        rom_ack_i,
    input  logic        rom_rvalid_i,
    input  logic [31:0] rom_rdata_i,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_o
);

    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TCW   = $clog2(MAX_OUT + 1);
    localparam int SW    = 8;

    logic [31:0]      fetch_pc_q,      fetch_pc_d;
    logic [OUT_W-1:0] outstanding_q,   outstanding_d;
    logic [OUT_W-1:0] discard_q,       discard_d;
    logic [OUT_W-1:0] ddisc_q,         ddisc_d;
    logic             dslot_pending_q, dslot_pending_d;
    logic             redir_pending_q, redir_pending_d;
    logic [31:0]      redir_target_q,  redir_target_d;

    fetch_entry_t     df_in;
    fetch_entry_t     df_head;
    logic [CNT_W-1:0] df_count;
    logic             df_full, df_empty, df_push, df_flush;
    logic [31:0]      tag_head;
    logic [TCW-1:0]   tag_count;
    logic             tag_full, tag_empty;

    logic             pop, redirect, issue, resp, resp_keep, resp_drop;
    logic [SW-1:0]    occupancy;
    logic [OUT_W-1:0] out_next, disc_after_resp, usable;
    logic             unused_sig;

    // Stall-vector decode and the issue throttle: data already queued or
    // still owed by the ROM must never exceed the prefetch capacity.
    assign pop       = (pause[1] == NoStop) && !df_empty;
    assign redirect  = (pause[1] == NoStop) && branch_flag_i;
    assign occupancy = SW'(df_count) - SW'(pop) + SW'(outstanding_q) - SW'(discard_q);
    assign rom_req_o = (rst != RstEnable) && (pause[0] == NoStop)
                     && (outstanding_q < OUT_W'(MAX_OUT))
                     && (occupancy < SW'(FIFO_DEPTH));
    assign rom_addr_o = fetch_pc_q;
    assign issue      = rom_req_o && rom_ack_i;

    // Responses for requests made before a reset are ignored via the zero count.
    assign resp            = rom_rvalid_i && (outstanding_q != '0);
    assign resp_drop       = resp && (discard_q != '0);
    assign resp_keep       = resp && (discard_q == '0);
    assign out_next        = outstanding_q + OUT_W'(issue) - OUT_W'(resp);
    assign disc_after_resp = discard_q - OUT_W'(resp_drop);
    assign usable          = out_next - disc_after_resp;

    assign df_in      = '{pc: tag_head, inst: rom_rdata_i};
    assign if_pc      = df_empty ? ZeroWord : df_head.pc;
    assign if_inst    = df_empty ? ZeroWord : df_head.inst;
    assign stallreq_o = df_empty;
    assign unused_sig = ^{pause[5:2], tag_count, tag_full, tag_empty, df_full};

    // Next-state for PC, in-flight bookkeeping and delay-slot tracking.
    always_comb begin
        fetch_pc_d      = fetch_pc_q;
        outstanding_d   = out_next;
        discard_d       = disc_after_resp;
        ddisc_d         = ddisc_q;
        dslot_pending_d = dslot_pending_q;
        redir_pending_d = redir_pending_q;
        redir_target_d  = redir_target_q;
        df_push         = resp_keep;
        df_flush        = 1'b0;

        if (issue) begin
            if (redir_pending_q) begin
                fetch_pc_d      = redir_target_q;
                redir_pending_d = 1'b0;
            end else begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
        end

        // The kept delay slot has arrived: start dropping the wrong-path words behind it.
        if (resp_keep && dslot_pending_q) begin
            dslot_pending_d = 1'b0;
            discard_d       = ddisc_q;
            ddisc_d         = '0;
        end

        if (redirect) begin
            if (!df_empty) begin
                // Head goes to IF/ID as the delay slot; everything behind it is wrong-path.
                df_flush   = 1'b1;
                df_push    = 1'b0;
                discard_d  = out_next;
                fetch_pc_d = branch_target_i;
            end else if (resp_keep) begin
                // The word landing this cycle is the delay slot.
                discard_d  = out_next;
                fetch_pc_d = branch_target_i;
            end else if (usable != '0) begin
                // Oldest useful in-flight word is the delay slot; drop the rest later.
                dslot_pending_d = 1'b1;
                ddisc_d         = usable - OUT_W'(1);
                fetch_pc_d      = branch_target_i;
            end else begin
                // Nothing in flight: fetch the sequential delay slot, then redirect.
                dslot_pending_d = 1'b1;
                ddisc_d         = '0;
                redir_pending_d = 1'b1;
                redir_target_d  = branch_target_i;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            fetch_pc_q      <= RESET_PC;
            outstanding_q   <= '0;
            discard_q       <= '0;
            ddisc_q         <= '0;
            dslot_pending_q <= 1'b0;
            redir_pending_q <= 1'b0;
            redir_target_q  <= '0;
        end else begin
            assert (!(redirect && (dslot_pending_q || redir_pending_q)));
            fetch_pc_q      <= fetch_pc_d;
            outstanding_q   <= outstanding_d;
            discard_q       <= discard_d;
            ddisc_q         <= ddisc_d;
            dslot_pending_q <= dslot_pending_d;
            redir_pending_q <= redir_pending_d;
            redir_target_q  <= redir_target_d;
        end
    end

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_data_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (df_flush),
        .push_i  (df_push),
        .data_i  (df_in),
        .pop_i   (pop),
        .data_o  (df_head),
        .count_o (df_count),
        .full_o  (df_full),
        .empty_o (df_empty)
    );

    fetch_fifo #(.WIDTH(32), .DEPTH(MAX_OUT)) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (1'b0),
        .push_i  (issue),
        .data_i  (fetch_pc_q),
        .pop_i   (resp),
        .data_o  (tag_head),
        .count_o (tag_count),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - randomized self-checking bench for if_fetch against a program-order model
module tb_if_fetch;

    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  pause = '0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic        rom_ack_i = 1'b0;
    logic        rom_rvalid_i = 1'b0;
    logic [31:0] rom_rdata_i = '0;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_o;

    if_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(2), .MAX_OUT(MAX_OUT)) dut (
        .clk             (clk),
        .rst             (rst),
        .pause           (pause),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .rom_req_o       (rom_req_o),
        .rom_addr_o      (rom_addr_o),
        .rom_ack_i       (rom_ack_i),
        .rom_rvalid_i    (rom_rvalid_i),
        .rom_rdata_i     (rom_rdata_i),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .stallreq_o      (stallreq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          rt;
    } rsp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    rsp_t rq[$];
    int   cyc = 0;
    int   last_rt = 0;

    int          pause_pct = 0;
    int          ack_pct = 100;
    int          lat_max = 1;
    int          br_pct = 0;
    int          fixed_pause = 0;
    bit          force_br = 0;
    logic [31:0] force_tgt = '0;

    logic [31:0] exp_pc = '0;
    bit          dslot_wait = 0;
    logic [31:0] dslot_tgt = '0;
    int          consumed = 0;
    bit          frz_valid = 0;
    logic [31:0] frz_pc = '0;
    logic [31:0] frz_inst = '0;
    logic [31:0] last_pc = '0;
    logic        last_stall = 1'b0;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return ((a * 32'h9E37_79B1) ^ 32'h0BAD_F00D) | 32'h1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        int lat;
        int rt;
        bit took;
        bit br;
        @(negedge clk);
        if (fixed_pause >= 0) pause = 6'(fixed_pause);
        else pause = {4'($urandom), ($urandom_range(0, 99) < pause_pct), ($urandom_range(0, 99) < pause_pct)};
        br = !dslot_wait && (force_br || ($urandom_range(0, 99) < br_pct));
        branch_flag_i   = br;
        branch_target_i = force_br ? force_tgt : (32'($urandom_range(0, 1023)) << 2);
        rom_ack_i       = ($urandom_range(0, 99) < ack_pct);
        if (rq.size() > 0 && rq[0].rt <= cyc) begin
            rom_rvalid_i = 1'b1;
            rom_rdata_i  = rom_word(rq[0].addr);
        end else begin
            rom_rvalid_i = 1'b0;
            rom_rdata_i  = $urandom;
        end
        #1;
        if (pause[0]) check("req_while_paused", 32'(rom_req_o), 32'h0);
        if (rom_req_o) check("addr_align", 32'(rom_addr_o[1:0]), 32'h0);
        if (stallreq_o) begin
            check("bubble_pc", if_pc, 32'h0);
            check("bubble_inst", if_inst, 32'h0);
        end
        if (frz_valid) begin
            check("hold_pc", if_pc, frz_pc);
            check("hold_inst", if_inst, frz_inst);
        end
        frz_valid = pause[1] && !stallreq_o;
        frz_pc    = if_pc;
        frz_inst  = if_inst;

        took = !pause[1] && !stallreq_o;
        if (took) begin
            check("if_pc", if_pc, exp_pc);
            check("if_inst", if_inst, rom_word(exp_pc));
            consumed++;
            if (dslot_wait) begin
                exp_pc     = dslot_tgt;
                dslot_wait = 0;
            end else begin
                exp_pc = exp_pc + 32'd4;
            end
        end
        if (br && !pause[1]) begin
            if (took) exp_pc = branch_target_i;
            else begin
                dslot_wait = 1;
                dslot_tgt  = branch_target_i;
            end
        end

        if (rom_rvalid_i) void'(rq.pop_front());
        if (rom_req_o && rom_ack_i) begin
            lat = int'($urandom_range(1, lat_max));
            rt  = cyc + lat;
            if (rt <= last_rt) rt = last_rt + 1;
            last_rt = rt;
            rq.push_back('{addr: rom_addr_o, rt: rt});
        end
        check("outstanding_le_max", 32'(rq.size() <= MAX_OUT), 32'h1);
        last_pc    = if_pc;
        last_stall = stallreq_o;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b1;
        pause           = '0;
        branch_flag_i   = 1'b0;
        branch_target_i = '0;
        rom_ack_i       = 1'b0;
        rom_rvalid_i    = 1'b0;
        rom_rdata_i     = '0;
        @(negedge clk);
        #1;
        check("rst_req", 32'(rom_req_o), 32'h0);
        check("rst_addr", rom_addr_o, 32'h0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_inst", if_inst, 32'h0);
        check("rst_stall", 32'(stallreq_o), 32'h1);
        rst = 1'b0;
        #1;
        check("first_req", 32'(rom_req_o), 32'h1);
        check("first_addr", rom_addr_o, 32'h0);
        rq.delete();
        last_rt    = cyc;
        exp_pc     = 32'h0;
        dslot_wait = 0;
        frz_valid  = 0;
    endtask

    task automatic cfg(input int pp, input int ap, input int lm, input int bp, input int fp);
        pause_pct   = pp;
        ack_pct     = ap;
        lat_max     = lm;
        br_pct      = bp;
        fixed_pause = fp;
    endtask

    initial begin
        int base;
        do_reset();

        // Zero-wait ROM: PCs 0,4,8 on consecutive cycles after two startup cycles.
        cfg(0, 100, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            if (k < 2) check("startup_stall", 32'(last_stall), 32'h1);
            else begin
                check("startup_stall", 32'(last_stall), 32'h0);
                check("startup_pc", last_pc, 32'((k - 2) * 4));
            end
        end

        // Hold IF/ID and issue for three cycles, then resume.
        cfg(0, 100, 1, 0, 3);
        repeat (3) step();
        cfg(0, 100, 1, 0, 0);
        repeat (8) step();

        // Drain with issue frozen, then branch on an empty buffer with nothing in flight.
        cfg(0, 100, 1, 0, 1);
        repeat (6) step();
        cfg(0, 100, 1, 0, 0);
        force_tgt = 32'h100;
        force_br  = 1;
        step();
        force_br  = 0;
        repeat (10) step();

        // Randomized mix of stalls, ack gaps, latencies and branches.
        base = consumed;
        cfg(20, 70, 3, 8, -1);
        repeat (3000) step();
        check("progress", 32'(consumed - base > 300), 32'h1);

        // Long latency with ack gaps.
        cfg(0, 50, 3, 0, 0);
        repeat (300) step();

        // Reset with requests in flight.
        cfg(0, 100, 3, 0, 0);
        repeat (5) step();
        do_reset();
        cfg(15, 80, 2, 6, -1);
        repeat (400) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
